// File: rtl/oport_arbiter.sv
// Output-port arbiter: round-robin packet grant with a wormhole lock held until
// the owner's tail flit, plus a watchdog that force-releases a stuck lock.
module oport_arbiter #(
  parameter int INPORTS   = 4,
  parameter int OWNW      = 2,
  parameter int WD_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               gen_enable,
  input  logic [INPORTS-1:0] req_i,
  input  logic [INPORTS-1:0] tail_i,
  output logic [INPORTS-1:0] grant_o,
  output logic               busy_o,
  output logic [OWNW-1:0]    owner_o,
  output logic               timeout_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOCKED  = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  localparam logic [15:0]     WD_LAST   = 16'(WD_CYCLES - 1);
  localparam logic            WD_EN     = (WD_CYCLES != 0);
  localparam logic [OWNW-1:0] LAST_PORT = OWNW'(INPORTS - 1);

  state_e             state_q, state_d;
  logic [INPORTS-1:0] grant_q, grant_d;
  logic               busy_q, busy_d;
  logic [OWNW-1:0]    owner_q, owner_d;
  logic               timeout_q, timeout_d;
  logic [OWNW-1:0]    rr_q, rr_d;
  logic [15:0]        wd_cnt_q, wd_cnt_d;

  logic [OWNW-1:0]    pick_idx;
  logic               pick_vld;
  logic [OWNW-1:0]    scan_pos;
  logic               owner_tail;
  logic               wd_expire;
  logic [OWNW-1:0]    next_ptr;

  // Scan downward in offset so the smallest offset from the pointer is written last and wins.
  always_comb begin
    pick_idx = rr_q;
    pick_vld = 1'b0;
    scan_pos = '0;
    for (int i = INPORTS - 1; i >= 0; i--) begin
      scan_pos = OWNW'((int'(rr_q) + i) % INPORTS);
      if (req_i[scan_pos]) begin
        pick_idx = scan_pos;
        pick_vld = 1'b1;
      end
    end
  end

  assign owner_tail = tail_i[owner_q];
  assign wd_expire  = WD_EN && (wd_cnt_q == WD_LAST);
  assign next_ptr   = (owner_q == LAST_PORT) ? '0 : owner_q + 1'b1;

  // NOTE: every output of this block is given a default first so no path leaves it unassigned,
  // which is what keeps synthesis from inferring latches.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    owner_d   = owner_q;
    timeout_d = 1'b0;
    rr_d      = rr_q;
    wd_cnt_d  = wd_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (gen_enable && pick_vld) begin
          state_d  = ST_LOCKED;
          grant_d  = INPORTS'(1) << pick_idx;
          busy_d   = 1'b1;
          owner_d  = pick_idx;
          wd_cnt_d = '0;
        end
      end
      ST_LOCKED: begin
        if (owner_tail || wd_expire) begin
          state_d   = ST_RELEASE;
          grant_d   = '0;
          busy_d    = 1'b0;
          rr_d      = next_ptr;
          timeout_d = !owner_tail;
        end else if (wd_cnt_q != 16'hFFFF) begin
          wd_cnt_d = wd_cnt_q + 16'd1;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      owner_q   <= '0;
      timeout_q <= 1'b0;
      rr_q      <= '0;
      wd_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      owner_q   <= owner_d;
      timeout_q <= timeout_d;
      rr_q      <= rr_d;
      wd_cnt_q  <= wd_cnt_d;
    end
  end

  assign grant_o   = grant_q;
  assign busy_o    = busy_q;
  assign owner_o   = owner_q;
  assign timeout_o = timeout_q;

endmodule

// File: doc/oport_arbiter.md
# oport_arbiter

Clocked packet-level arbiter owning one router output port, shared by up to INPORTS input port modules. Each input port's request generator raises a level request when its route selector targets this port. The arbiter grants the port to one requester at a time, round-robin, and holds the grant (wormhole lock) until that requester reports its tail flit has passed. A watchdog force-releases a lock held too long.

## Interface
- INPORTS, 4: number of requesting input ports (2..8).
- OWNW, 2: owner index width, equal to clog2(INPORTS).
- WD_CYCLES, 1024: watchdog limit in locked cycles (1..65535); 0 disables the watchdog.

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- gen_enable  in  1  high = new grants allowed; low blocks new grants only, an in-flight packet completes.
- req_i  in  INPORTS  level request per input port; held until its grant is seen.
- tail_i  in  INPORTS  one-cycle pulse: tail flit of that port's packet has left the output port.
- grant_o  out  INPORTS  one-hot (or zero) PacketEnable back to the input ports; registered.
- busy_o  out  1  high while the port is locked.
- owner_o  out  OWNW  index of the current owner; valid while busy_o, holds last owner otherwise.
- timeout_o  out  1  one-cycle pulse when the watchdog force-releases a lock.

## Operation
- States: IDLE, LOCKED, RELEASE. Reset sets state IDLE, grant_o=0, busy_o=0, owner_o=0, timeout_o=0, rr pointer=0, watchdog count=0.
- IDLE:
  - if gen_enable and any req_i bit set, pick the first set bit scanning upward from the rr pointer with wrap (pointer index first).
  - Load owner_o, set grant_o one-hot at the winner, go to LOCKED.
  - Otherwise stay in IDLE.
- LOCKED:
  - grant_o and busy_o are held; watchdog count increments each cycle.
  - tail_i[owner] = 1: go to RELEASE; grant_o=0; rr pointer = (owner+1) mod INPORTS.
  - tail_i on any non-owner bit: ignored.
  - Owner dropping req_i while locked: ignored; the lock is held until tail or watchdog.
  - gen_enable falling while locked: no effect on the current lock.
- Watchdog:
  - Count clears to 0 on entry to LOCKED.
  - If WD_CYCLES≠0 and count==WD_CYCLES-1 with no owner tail that cycle: go to RELEASE, grant_o=0, timeout_o=1 for exactly one cycle, rr pointer advanced as for a tail.
  - Tail and expiry in the same cycle: tail wins, no timeout_o.
- RELEASE: one cycle with grant_o=0 and busy_o=0, then IDLE. This gives the requester a cycle to drop req_i.
- Count is 16 bits, saturating; it never wraps.
- Pointer arithmetic is mod INPORTS; owner INPORTS-1 wraps the pointer to 0.
- Requests on bits ≥ INPORTS do not exist. grant_o is never multi-hot.

## Timing
- Grant latency: req_i sampled high in IDLE at edge N gives grant_o high after edge N (visible in cycle N+1).
- Release: tail_i[owner] sampled at edge K:
  - grant_o and busy_o are low from cycle K+1 (RELEASE).
  - IDLE at K+2.
  - Earliest next grant is visible in cycle K+3.
- Back-to-back packets from the same port therefore have a minimum 2-cycle bubble.
- Watchdog: with no tail, grant_o is high for exactly WD_CYCLES cycles. timeout_o is high in the first RELEASE cycle.
- Reset low at any edge, including mid-packet: all outputs return to reset values the next cycle, the lock is abandoned, and no timeout_o is produced.
- All outputs are registered; no combinational path from any input to any output.

## Test plan
- Reset then single request: req_i=0100 -> grant_o=0100 one cycle later, owner_o=2, busy_o=1. Tail pulse on bit 2 -> grant_o=0000 next cycle, IDLE one cycle after that.
- Round-robin fairness: req_i=1111 held, tail issued 3 cycles after each grant -> grant order 0,1,2,3,0; bubbles are exactly 2 cycles.
- Foreign tail and dropped request: owner 1 locked; pulse tail_i=0001, deassert req_i[1] -> grant_o stays 0010 until tail_i=0010.
- Watchdog: WD_CYCLES=8, owner 3, no tail -> grant_o high exactly 8 cycles, timeout_o one pulse. Next grant goes to port 0 if requesting. Tail coincident with expiry -> no timeout_o.
- gen_enable: low with req_i=0011 -> no grant. Drop gen_enable while owner 0 locked -> packet completes on tail, no new grant until gen_enable returns high.
- Mid-packet reset: assert reset during LOCKED -> next cycle grant_o=0, busy_o=0, owner_o=0. After release, req_i=1010 grants port 1 (pointer back at 0).
